// File: rtl/skew_feeder_pkg.sv
// Shared types and helpers for the skewed multi-lane operand feeder.
package skew_feeder_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BLOCK_SIZE_DEF = 3;
    localparam int NUM_LANES_DEF  = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Cycles needed for the last lane's last element to leave the diagonal.
    function automatic int stream_len(input int block_size, input int num_lanes);
        return block_size + num_lanes - 1;
    endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Block-input handshake plus skewed lane outputs of the feeder.
interface skew_feeder_if
    import skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF
);
    // A block transfers on a rising clk edge where in_valid & in_ready are both high;
    // in_data/msb_first must be stable while in_valid is high and matter only at that edge.
    logic                                      in_valid;
    logic                                      in_ready;
    logic [NUM_LANES*BLOCK_SIZE*DATA_WIDTH-1:0] in_data;
    logic                                      msb_first;
    logic                                      stall;
    logic [NUM_LANES*DATA_WIDTH-1:0]           out_data;
    logic [NUM_LANES-1:0]                      out_valid;
    logic                                      busy;
    logic                                      done;
    state_e                                    state;

    modport slave (
        input  in_valid, in_data, msb_first, stall,
        output in_ready, out_data, out_valid, busy, done, state
    );

    modport master (
        output in_valid, in_data, msb_first, stall,
        input  in_ready, out_data, out_valid, busy, done, state
    );

endinterface

// File: rtl/skew_feeder_lane.sv
// One feeder lane: holds its captured block and emits element (t - LANE), optionally reversed.
module skew_feeder_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_SIZE = 3,
    parameter int LANE       = 0,
    parameter int CW         = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             hold_i,
    input  logic                             load_i,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] elems_i,
    input  logic                             msb_first_i,
    input  logic                             active_i,
    input  logic [CW-1:0]                    cnt_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o
);
    logic [DATA_WIDTH-1:0] elem_q [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] elem_d [BLOCK_SIZE];
    logic                  rev_q, rev_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    int                    pos;
    int                    sel;

    // Outputs are computed from next-cycle counter and block so they register in step with the FSM.
    always_comb begin
        elem_d  = elem_q;
        rev_d   = rev_q;
        data_d  = '0;
        valid_d = 1'b0;
        sel     = 0;
        if (load_i) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                elem_d[j] = elems_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
            rev_d = msb_first_i;
        end
        pos = int'(cnt_i) - LANE;
        if (active_i && pos >= 0 && pos < BLOCK_SIZE) begin
            valid_d = 1'b1;
            sel     = rev_d ? (BLOCK_SIZE - 1 - pos) : pos;
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                if (j == sel) begin
                    data_d = elem_d[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                elem_q[j] <= '0;
            end
            rev_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            elem_q  <= elem_d;
            rev_q   <= rev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/skew_feeder.sv
// Skewed operand feeder: accepts one block for all lanes, streams lane k delayed by k cycles.
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    skew_feeder_if.slave  bus
);
    localparam int            T    = stream_len(BLOCK_SIZE, NUM_LANES);
    localparam int            CW   = $clog2(T + 1);
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, done_q;
    logic          accept;

    assign bus.in_ready = ~reset & ~bus.stall & ((state_q == ST_IDLE) | (cnt_q == LAST));
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_STREAM;
                        cnt_d   = '0;
                    end
                end
                ST_STREAM: begin
                    if (cnt_q == LAST) begin
                        // A new block at the last cycle chains straight into t=0.
                        cnt_d = '0;
                        if (!accept) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.stall) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_STREAM);
            done_q  <= (state_d == ST_STREAM) && (cnt_d == LAST);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        skew_feeder_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .BLOCK_SIZE (BLOCK_SIZE),
            .LANE       (k),
            .CW         (CW)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .hold_i      (bus.stall),
            .load_i      (accept),
            .elems_i     (bus.in_data[k*BLOCK_SIZE*DATA_WIDTH +: BLOCK_SIZE*DATA_WIDTH]),
            .msb_first_i (bus.msb_first),
            .active_i    (state_d == ST_STREAM),
            .cnt_i       (cnt_d),
            .data_o      (bus.out_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o     (bus.out_valid[k])
        );
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: directed block scenarios plus random traffic against a diagonal-wavefront model.
module tb_skew_feeder;
    import skew_feeder_pkg::*;

    localparam int DW = 8;
    localparam int B  = 3;
    localparam int L  = 3;
    localparam int T  = B + L - 1;
    localparam int IW = L * B * DW;
    localparam int EW = 1 + L + L * DW;

    localparam logic [IW-1:0] D1 = 72'h23_22_21_13_12_11_03_02_01;
    localparam logic [IW-1:0] D2 = 72'h99_98_97_89_88_87_79_78_77;
    localparam logic [IW-1:0] D3 = 72'hC2_C1_C0_B2_B1_B0_A2_A1_A0;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    skew_feeder_if #(.DATA_WIDTH(DW), .BLOCK_SIZE(B), .NUM_LANES(L)) bus ();

    skew_feeder #(.DATA_WIDTH(DW), .BLOCK_SIZE(B), .NUM_LANES(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: lane k at stream cycle t carries element t-k (mirrored when msb first).
    task automatic push_block(input logic [IW-1:0] d, input logic msb);
        logic [EW-1:0] w;
        int            e;
        int            idx;
        for (int t = 0; t < T; t++) begin
            w = '0;
            for (int k = 0; k < L; k++) begin
                e = t - k;
                if (e >= 0 && e < B) begin
                    idx = msb ? (B - 1 - e) : e;
                    w[k*DW +: DW] = d[(k*B + idx)*DW +: DW];
                    w[L*DW + k]   = 1'b1;
                end
            end
            w[EW-1] = (t == T - 1);
            exp_q.push_back(w);
        end
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall;
    logic          prev_busy;
    logic [EW-1:0] prev_obs;
    logic [EW-1:0] obs;
    logic [EW-1:0] w_exp;
    logic          exp_ready;

    initial begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
        prev_obs   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_in_ready", 64'(bus.in_ready), 64'd0);
                prev_stall = 1'b0;
            end else begin
                obs = {bus.done, bus.out_valid, bus.out_data};
                if (prev_stall) begin
                    check("stall_hold", 64'({bus.busy, obs}), 64'({prev_busy, prev_obs}));
                end
                if (bus.busy && !bus.stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(obs), 64'd0);
                    end else begin
                        w_exp = exp_q.pop_front();
                        check("stream_word", 64'(obs), 64'(w_exp));
                    end
                end else if (!bus.busy) begin
                    check("idle_outputs", 64'({bus.state, obs}), 64'd0);
                    check("no_bubble", 64'(exp_q.size()), 64'd0);
                end
                exp_ready = !bus.stall && (exp_q.size() == 0);
                check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
                if (bus.in_valid && bus.in_ready) push_block(bus.in_data, bus.msb_first);
                prev_stall = bus.stall;
                prev_busy  = bus.busy;
                prev_obs   = obs;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic send_block(input logic [IW-1:0] d, input logic msb);
        bus.in_data   = d;
        bus.msb_first = msb;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #2;
            if (!bus.busy && exp_q.size() == 0) got = 1'b1;
        end
        if (!got) check("drain_timeout", 64'd0, 64'd1);
        step();
    endtask

    function automatic logic [IW-1:0] rand_block();
        logic [IW-1:0] r;
        for (int i = 0; i < L * B; i++) r[i*DW +: DW] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Global bound so a stuck DUT still produces a verdict.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.msb_first = 1'b0;
        bus.stall     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({bus.busy, bus.done, bus.out_valid, bus.out_data, bus.state}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Single block, lsb first: t2 is the full diagonal.
        send_block(D1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t1_t2_data", 64'(bus.out_data), 64'h21_12_03);
        check("t1_t2_valid", 64'(bus.out_valid), 64'b111);
        wait_idle();

        // Same block, msb first.
        send_block(D1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t2_t2_data", 64'(bus.out_data), 64'h23_12_01);
        wait_idle();

        // Back-to-back blocks with in_valid held.
        bus.in_data   = D1;
        bus.msb_first = 1'b0;
        bus.in_valid  = 1'b1;
        wait_accept();
        bus.in_data   = D3;
        wait_accept();
        bus.in_valid  = 1'b0;
        wait_idle();

        // Two-cycle stall at t2.
        send_block(D1, 1'b0);
        step();
        step();
        bus.stall = 1'b1;
        @(negedge clk);
        check("t4_stall_ready", 64'(bus.in_ready), 64'd0);
        check("t4_stall_data", 64'(bus.out_data), 64'h21_12_03);
        step();
        step();
        bus.stall = 1'b0;
        wait_idle();

        // Reset in the middle of a stream, then a fresh block.
        send_block(D1, 1'b0);
        step();
        step();
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_after_reset", 64'({bus.busy, bus.out_valid, bus.out_data}), 64'd0);
        check("t5_ready", 64'(bus.in_ready), 64'd1);
        step();
        send_block(D1, 1'b0);
        wait_idle();

        // New data offered mid-stream must be ignored.
        send_block(D1, 1'b0);
        step();
        bus.in_data   = D2;
        bus.msb_first = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        step();
        step();
        bus.in_valid  = 1'b0;
        wait_idle();

        // Random traffic with stalls.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = rand_block();
            bus.msb_first = 1'($urandom_range(0, 1));
            bus.stall     = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        wait_idle();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
